rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter with a per-owner hold limit.
// Grants are registered and the releasing owner always drops to lowest priority.
module rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_v_q, gnt_v_d;
    logic       release_c;
    logic [1:0] next_ptr_c;

    // First set request scanning base, base+1, base+2, base+3 (mod 4).
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] r);
        logic [1:0] idx;
        pick = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    assign release_c  = !req[owner_q] || (hold_cnt_q == MAX_HOLD_C) || !en;
    assign next_ptr_c = owner_q + 2'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            owner_q    <= 2'd0;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 4'd0;
            gnt_id_q   <= 2'd0;
            gnt_v_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_v_q    <= gnt_v_d;
        end
    end

    // Next-state logic; new requests are only looked at from IDLE or on release
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = 8'd0;
                if (en && (req != 4'd0)) begin
                    state_d    = GRANT;
                    owner_d    = pick(ptr_q, req);
                    hold_cnt_d = 8'd1;
                end
            end
            GRANT: begin
                if (!release_c) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    ptr_d = next_ptr_c;
                    if (en && (req != 4'd0)) begin
                        owner_d    = pick(next_ptr_c, req);
                        hold_cnt_d = 8'd1;
                    end else begin
                        state_d    = IDLE;
                        hold_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in the same edge
    always_comb begin
        gnt_d    = 4'd0;
        gnt_id_d = 2'd0;
        gnt_v_d  = 1'b0;
        if (state_d == GRANT) begin
            gnt_d    = 4'b0001 << owner_d;
            gnt_id_d = owner_d;
            gnt_v_d  = 1'b1;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign gnt_v  = gnt_v_q;

endmodule
